irq_rr_scheduler: RTL and testbench

- Shares one CPU interrupt line and one ack handshake among NUM_SRC event sources.
- Latches rising edges per source, picks one pending source round-robin, drives irq with the granted source ID, and waits for ack_in or a timeout.
- Emits a one-hot served pulse that feeds the per-source service counters and the APB register map.
- Sits between the event sources and the interrupt-handler/counter core, under the APB control register's enable mask.

---
 rtl/irq_rr_scheduler_pkg.sv | 16 +
 rtl/irq_rr_scheduler_rr_pick.sv | 29 ++
 rtl/irq_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_irq_rr_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_rr_scheduler_pkg.sv
// Shared definitions for the interrupt round-robin scheduler: FSM encoding and
// default sizing.
package irq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } sched_state_e;

    localparam int NUM_SRC_DEF     = 10;
    localparam int ID_W_DEF        = 4;
    localparam int ACK_TIMEOUT_DEF = 255;
    localparam int TO_W_DEF        = 8;

endpackage

// File: rtl/irq_rr_scheduler_rr_pick.sv
// Combinational round-robin priority encoder: returns the first set bit of elig
// starting one position after last_grant, wrapping modulo NUM_SRC.
module rr_pick #(
    parameter int NUM_SRC = 10,
    parameter int ID_W    = 4
) (
    input  logic [NUM_SRC-1:0] elig,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    pick,
    output logic               any
);

    int idx;

    // Scan from the farthest offset down so the nearest eligible source wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_SRC;
            if (elig[idx]) begin
                pick = ID_W'(idx);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_rr_scheduler.sv
// Shares one CPU interrupt line and ack handshake among NUM_SRC event sources.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no grant outstanding; grant next eligible source if any
//   ASSERT  | irq high for irq_id; waiting for ack_in or timeout
//   RELEASE | ack seen; waiting for ack_in to drop before re-arbitrating
module irq_rr_scheduler
    import irq_sched_pkg::*;
#(
    parameter int NUM_SRC     = NUM_SRC_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [NUM_SRC-1:0] enable_mask,
    input  logic               ack_in,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] served,
    output logic               timeout_err
);

    sched_state_e       state_q, state_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] served_q, served_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               irq_q, irq_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr_mask;
    logic [ID_W-1:0]    pick;
    logic               any;

    assign src_edge = src_req & ~src_q & enable_mask;
    assign elig     = pending_q & enable_mask;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .elig       (elig),
        .last_grant (last_grant_q),
        .pick       (pick),
        .any        (any)
    );

    // Next-state logic for the handshake FSM, pending latch and pulse outputs.
    always_comb begin
        state_d       = state_q;
        src_d         = src_req;
        tcnt_d        = tcnt_q;
        last_grant_d  = last_grant_q;
        irq_id_d      = irq_id_q;
        irq_d         = irq_q;
        served_d      = '0;
        timeout_err_d = 1'b0;
        clr_mask      = '0;

        case (state_q)
            IDLE: begin
                if (any) begin
                    irq_id_d     = pick;
                    last_grant_d = pick;
                    irq_d        = 1'b1;
                    tcnt_d       = '0;
                    state_d      = ASSERT;
                end
            end
            ASSERT: begin
                if (ack_in) begin
                    irq_d    = 1'b0;
                    served_d = NUM_SRC'(1) << irq_id_q;
                    clr_mask = NUM_SRC'(1) << irq_id_q;
                    state_d  = RELEASE;
                end else if (tcnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    // Pending bit is kept; last_grant already moved past it.
                    irq_d         = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!ack_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A fresh edge in the same cycle as the clear wins.
        pending_d = (pending_q & ~clr_mask) | src_edge;
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            src_q         <= '0;
            pending_q     <= '0;
            served_q      <= '0;
            tcnt_q        <= '0;
            last_grant_q  <= ID_W'(NUM_SRC - 1);
            irq_id_q      <= '0;
            irq_q         <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            pending_q     <= pending_d;
            served_q      <= served_d;
            tcnt_q        <= tcnt_d;
            last_grant_q  <= last_grant_d;
            irq_id_q      <= irq_id_d;
            irq_q         <= irq_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign irq         = irq_q;
    assign irq_id      = irq_id_q;
    assign pending     = pending_q;
    assign served      = served_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_irq_rr_scheduler.sv
// Directed bench for irq_rr_scheduler with a short ack timeout (4 cycles).
module tb_irq_rr_scheduler;

    localparam int NS = 10;
    localparam int IW = 4;

    logic          PCLK;
    logic          PRESETn;
    logic [NS-1:0] src_req;
    logic [NS-1:0] enable_mask;
    logic          ack_in;
    logic          irq;
    logic [IW-1:0] irq_id;
    logic [NS-1:0] pending;
    logic [NS-1:0] served;
    logic          timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    irq_rr_scheduler #(
        .NUM_SRC     (NS),
        .ID_W        (IW),
        .ACK_TIMEOUT (4),
        .TO_W        (8)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .src_req     (src_req),
        .enable_mask (enable_mask),
        .ack_in      (ack_in),
        .irq         (irq),
        .irq_id      (irq_id),
        .pending     (pending),
        .served      (served),
        .timeout_err (timeout_err)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
    endtask

    // Called in the first cycle irq should be high for exp_id; acks two cycles
    // later, checks the served pulse, and returns in the cycle after RELEASE.
    task automatic serve(input int exp_id, input string tag);
        logic [NS-1:0] one;
        one = NS'(1) << exp_id;
        chk({tag, "_irq"}, irq, 1'b1);
        chk({tag, "_id"}, irq_id, exp_id);
        tick();
        tick();
        ack_in = 1'b1;
        tick();
        chk({tag, "_served"}, served, one);
        chk({tag, "_irq_low"}, irq, 1'b0);
        ack_in = 1'b0;
        tick();
        chk({tag, "_served_1cyc"}, served, 0);
        tick();
    endtask

    initial begin
        PRESETn     = 1'b0;
        src_req     = '0;
        enable_mask = '1;
        ack_in      = 1'b0;
        tick();
        tick();
        chk("rst_irq", irq, 0);
        chk("rst_id", irq_id, 0);
        chk("rst_pending", pending, 0);
        chk("rst_served", served, 0);
        chk("rst_toerr", timeout_err, 0);
        PRESETn = 1'b1;
        tick();

        // Single event on source 3; ack arrives on the last allowed cycle.
        src_req[3] = 1'b1;
        tick();
        chk("t1_pending", pending, 10'h008);
        chk("t1_irq_early", irq, 0);
        tick();
        chk("t1_irq", irq, 1);
        chk("t1_id", irq_id, 3);
        tick();
        tick();
        tick();
        chk("t1_irq_held", irq, 1);
        ack_in = 1'b1;
        tick();
        chk("t1_served", served, 10'h008);
        chk("t1_irq_low", irq, 0);
        chk("t1_pending_clr", pending, 0);
        chk("t1_no_toerr", timeout_err, 0);
        chk("t1_id_hold", irq_id, 3);
        ack_in = 1'b0;
        src_req = '0;
        tick();
        chk("t1_served_1cyc", served, 0);
        tick();
        chk("t1_idle_irq", irq, 0);

        // Fairness from reset: 0, 5, 9 then wrap 0, 9.
        do_reset();
        src_req = 10'h221;
        tick();
        chk("t2_pending", pending, 10'h221);
        tick();
        serve(0, "t2_g0");
        serve(5, "t2_g5");
        serve(9, "t2_g9");
        chk("t2_done_irq", irq, 0);
        chk("t2_done_pending", pending, 0);
        src_req = '0;
        tick();
        src_req = 10'h201;
        tick();
        tick();
        serve(0, "t2w_g0");
        serve(9, "t2w_g9");
        src_req = '0;
        tick();

        // Timeout on source 2 with no ack.
        do_reset();
        src_req[2] = 1'b1;
        tick();
        tick();
        chk("t3_id", irq_id, 2);
        for (int i = 0; i < 4; i++) begin
            chk("t3_irq_high", irq, 1);
            chk("t3_no_toerr", timeout_err, 0);
            tick();
        end
        chk("t3_irq_drop", irq, 0);
        chk("t3_toerr", timeout_err, 1);
        chk("t3_pending_kept", pending, 10'h004);
        chk("t3_no_served", served, 0);
        tick();
        chk("t3_reassert", irq, 1);
        chk("t3_reassert_id", irq_id, 2);
        chk("t3_toerr_1cyc", timeout_err, 0);
        ack_in = 1'b1;
        tick();
        chk("t3_served", served, 10'h004);
        ack_in = 1'b0;
        src_req = '0;
        tick();
        tick();

        // Edge on a masked source is dropped and never granted.
        do_reset();
        enable_mask = 10'h37F;
        src_req[7] = 1'b1;
        tick();
        chk("t4_pending", pending, 0);
        tick();
        chk("t4_irq", irq, 0);
        enable_mask = '1;
        tick();
        tick();
        chk("t4_irq_unmask", irq, 0);
        chk("t4_pending_unmask", pending, 0);
        src_req = '0;
        tick();

        // New edge on granted source 4 coincides with ack.
        do_reset();
        src_req[4] = 1'b1;
        tick();
        tick();
        chk("t5_irq", irq, 1);
        chk("t5_id", irq_id, 4);
        src_req = '0;
        tick();
        src_req[4] = 1'b1;
        ack_in = 1'b1;
        tick();
        chk("t5_served", served, 10'h010);
        chk("t5_pending_set_wins", pending, 10'h010);
        chk("t5_irq_low", irq, 0);
        ack_in = 1'b0;
        tick();
        chk("t5_release_irq", irq, 0);
        tick();
        chk("t5_regrant", irq, 1);
        chk("t5_regrant_id", irq_id, 4);
        ack_in = 1'b1;
        tick();
        chk("t5_served2", served, 10'h010);
        chk("t5_pending_clr", pending, 0);
        ack_in = 1'b0;
        src_req = '0;
        tick();
        tick();

        // Reset while source 2 is asserted; afterwards 0 beats 5.
        src_req[2] = 1'b1;
        tick();
        tick();
        chk("t6_irq", irq, 1);
        chk("t6_id", irq_id, 2);
        PRESETn = 1'b0;
        src_req = '0;
        tick();
        PRESETn = 1'b1;
        chk("t6_irq_rst", irq, 0);
        chk("t6_pending_rst", pending, 0);
        chk("t6_served_rst", served, 0);
        tick();
        chk("t6_served_after", served, 0);
        chk("t6_irq_after", irq, 0);
        src_req = 10'h021;
        tick();
        tick();
        serve(0, "t6_g0");
        serve(5, "t6_g5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
